fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
// Top-level instruction sequencer for the CPU. Runs fetch (PC -> RAM -> IR) and PC increment.
// Hands each decoded instruction to the execute controller through a start/waiting handshake.
// Performs the memory phase of LDR/STR. Sits between the RAM, PC/IR/data-address registers and the execute controller.
// PARAMETERS
// MEM_LAT       1   RAM read/write latency in cycles (>=1); mem_cmd held this long per access
// EXEC_GUARD    2   cycles after exec_start during which exec_waiting is ignored (>=1)
// EXEC_TIMEOUT  15  max cycles in EXEC before fault; 4-bit counter, must be <=15 and >EXEC_GUARD
// PORTS
// clk           in   1  system clock, rising edge
// rst           in   1  synchronous, active-high reset
// opcode        in   3  IR[15:13]; 011=LDR, 100=STR, 111=HALT, others = execute-only
// exec_waiting  in   1  execute controller idle flag
// reset_pc      out  1  PC mux selects 0
// load_pc       out  1  PC register load enable
// load_ir       out  1  IR load enable (captures RAM dout)
// load_addr     out  1  data-address register load enable (captures datapath C)
// addr_sel      out  1  RAM address mux: 0=PC, 1=data-address register
// mem_cmd       out  2  00=NONE, 01=READ, 10=WRITE
// exec_start    out  1  one-cycle start pulse to execute controller
// ldr_wb        out  1  one-cycle pulse: write RAM dout into Rd (LDR only)
// halted        out  1  high in HALT state
// fault         out  1  sticky; set on execute timeout, cleared only by rst
// BEHAVIOUR
// - Moore FSM; all outputs decoded from state (fault is a register). rst=1 forces RST at the next edge, including mid-access or mid-execute.
// - States and outputs (unlisted outputs are 0):
//   RST:    reset_pc=1, load_pc=1 -> IF
//   IF:     mem_cmd=01, addr_sel=0. Stays MEM_LAT cycles (cnt 0..MEM_LAT-1) -> LDIR
//   LDIR:   mem_cmd=01, load_ir=1 -> UPC
//   UPC:    load_pc=1 (PC+1 path) -> DEC
//   DEC:    opcode=111 -> HALT; else exec_start=1 -> EXEC (cnt cleared)
//   EXEC:   cnt increments each cycle. Once cnt>=EXEC_GUARD and exec_waiting=1:
//           LDR/STR -> ADDR; others -> IF.
//           If cnt reaches EXEC_TIMEOUT first -> HALT with fault<=1.
//   ADDR:   load_addr=1 -> MEM
//   MEM:    addr_sel=1. mem_cmd=01 (LDR) or 10 (STR), held MEM_LAT cycles.
//           Then LDR -> WB; STR -> IF.
//   WB:     addr_sel=1, mem_cmd=01, ldr_wb=1 -> IF
//   HALT:   halted=1. Absorbing until rst.
// - Reset values (RST state): reset_pc=1, load_pc=1. All other outputs 0, including fault=0.
// - Latency:
//   - Non-memory instruction: 1 (RST, first only) + MEM_LAT + 3 + EXEC cycles.
//   - STR adds 1+MEM_LAT cycles; LDR adds 2+MEM_LAT cycles.
// - opcode is sampled only in DEC, EXEC and MEM; it is stable because IR loads only in LDIR.
// - exec_start never asserts again while in EXEC; at most one instruction is in flight.
// - The timeout check has priority over completion when both occur in the same cycle (-> fault).
// - Counter width is 4 bits. It saturates and never wraps.
// TESTING
// 1. rst=1 for 2 cycles, release, MEM_LAT=1 -> RST,IF,LDIR,UPC,DEC.
//    reset_pc=load_pc=1 in cycle 0; load_ir=1 in cycle 2; exec_start=1 in cycle 4.
// 2. opcode=110, exec_waiting low 3 cycles after guard, then high -> back to IF.
//    exec_start is exactly one pulse; no load_addr is issued.
// 3. opcode=011 (LDR), MEM_LAT=2 -> after EXEC: load_addr 1 cycle, then mem_cmd=01 with addr_sel=1 for 2 cycles.
//    ldr_wb=1 for exactly 1 cycle, then IF.
// 4. opcode=100 (STR) -> mem_cmd=10 for MEM_LAT cycles with addr_sel=1; ldr_wb never asserts; next state IF.
// 5. opcode=111 -> halted=1 and held for 20 cycles with exec_start=0; rst=1 -> RST.
// 6. exec_waiting held 0 -> after 15 EXEC cycles: halted=1, fault=1.
//    rst asserted during EXEC or MEM -> RST next edge, fault=0, mem_cmd=00.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Handshake and control bundle between the fetch sequencer and the rest of the CPU.
// The master drives RAM/register strobes; the slave supplies the opcode and execute-idle flag.
interface fetch_sequencer_if;
  logic [2:0] opcode;
  logic       exec_waiting;
  logic       reset_pc;
  logic       load_pc;
  logic       load_ir;
  logic       load_addr;
  logic       addr_sel;
  logic [1:0] mem_cmd;
  logic       exec_start;
  logic       ldr_wb;
  logic       halted;
  logic       fault;

  modport master (
    input  opcode, exec_waiting,
    output reset_pc, load_pc, load_ir, load_addr, addr_sel, mem_cmd,
           exec_start, ldr_wb, halted, fault
  );

  modport slave (
    output opcode, exec_waiting,
    input  reset_pc, load_pc, load_ir, load_addr, addr_sel, mem_cmd,
           exec_start, ldr_wb, halted, fault
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction sequencer: fetch, PC increment, execute handoff and LDR/STR memory phase.
// Latency MEM_LAT+3+exec cycles per instruction; stalls in EXEC until exec_waiting, faults on timeout.
module fetch_sequencer #(
  parameter int MEM_LAT      = 1,
  parameter int EXEC_GUARD   = 2,
  parameter int EXEC_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus
);

  localparam logic [2:0] OP_LDR    = 3'b011;
  localparam logic [2:0] OP_STR    = 3'b100;
  localparam logic [2:0] OP_HALT   = 3'b111;
  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [3:0] LAT_LAST  = 4'(MEM_LAT - 1);
  localparam logic [3:0] GUARD     = 4'(EXEC_GUARD);
  localparam logic [3:0] TMO_LAST  = 4'(EXEC_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_RST, S_IF, S_LDIR, S_UPC, S_DEC, S_EXEC, S_ADDR, S_MEM, S_WB, S_HALT
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       fault_q, fault_set;
  logic       is_mem_op;

  logic       reset_pc, load_pc, load_ir, load_addr, addr_sel;
  logic [1:0] mem_cmd;
  logic       exec_start, ldr_wb, halted;

  assign is_mem_op = (bus.opcode == OP_LDR) || (bus.opcode == OP_STR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RST;
      cnt     <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (fault_set) fault_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    fault_set  = 1'b0;
    reset_pc   = 1'b0;
    load_pc    = 1'b0;
    load_ir    = 1'b0;
    load_addr  = 1'b0;
    addr_sel   = 1'b0;
    mem_cmd    = CMD_NONE;
    exec_start = 1'b0;
    ldr_wb     = 1'b0;
    halted     = 1'b0;
    case (state)
      S_RST: begin
        reset_pc  = 1'b1;
        load_pc   = 1'b1;
        state_nxt = S_IF;
      end
      S_IF: begin
        mem_cmd = CMD_READ;
        if (cnt >= LAT_LAST) state_nxt = S_LDIR;
      end
      S_LDIR: begin
        mem_cmd   = CMD_READ;
        load_ir   = 1'b1;
        state_nxt = S_UPC;
      end
      S_UPC: begin
        load_pc   = 1'b1;
        state_nxt = S_DEC;
      end
      S_DEC: begin
        if (bus.opcode == OP_HALT) begin
          state_nxt = S_HALT;
        end else begin
          exec_start = 1'b1;
          state_nxt  = S_EXEC;
        end
      end
      S_EXEC: begin
        // Timeout wins over a completion seen in the same cycle.
        if (cnt >= TMO_LAST) begin
          state_nxt = S_HALT;
          fault_set = 1'b1;
        end else if (cnt >= GUARD && bus.exec_waiting) begin
          state_nxt = is_mem_op ? S_ADDR : S_IF;
        end
      end
      S_ADDR: begin
        load_addr = 1'b1;
        state_nxt = S_MEM;
      end
      S_MEM: begin
        addr_sel = 1'b1;
        mem_cmd  = (bus.opcode == OP_STR) ? CMD_WRITE : CMD_READ;
        if (cnt >= LAT_LAST) state_nxt = (bus.opcode == OP_LDR) ? S_WB : S_IF;
      end
      S_WB: begin
        addr_sel  = 1'b1;
        mem_cmd   = CMD_READ;
        ldr_wb    = 1'b1;
        state_nxt = S_IF;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = S_RST;
    endcase
    // Counter restarts on every state change and saturates otherwise.
    if (state_nxt != state) cnt_nxt = '0;
    else if (cnt == 4'hF)   cnt_nxt = cnt;
    else                    cnt_nxt = cnt + 4'd1;
  end

  assign bus.reset_pc   = reset_pc;
  assign bus.load_pc    = load_pc;
  assign bus.load_ir    = load_ir;
  assign bus.load_addr  = load_addr;
  assign bus.addr_sel   = addr_sel;
  assign bus.mem_cmd    = mem_cmd;
  assign bus.exec_start = exec_start;
  assign bus.ldr_wb     = ldr_wb;
  assign bus.halted     = halted;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: per-instruction expected output traces built from the cycle rules,
// replayed against a MEM_LAT=1 and a MEM_LAT=2 instance with random execute timing.
module tb_fetch_sequencer;
  localparam int G = 2;
  localparam int T = 15;

  // Output vector: {reset_pc,load_pc,load_ir,load_addr,addr_sel,mem_cmd[1:0],exec_start,ldr_wb,halted,fault}
  localparam logic [10:0] V_RST  = 11'h600;
  localparam logic [10:0] V_IF   = 11'h010;
  localparam logic [10:0] V_LDIR = 11'h110;
  localparam logic [10:0] V_UPC  = 11'h200;
  localparam logic [10:0] V_DEC  = 11'h008;
  localparam logic [10:0] V_IDLE = 11'h000;
  localparam logic [10:0] V_ADDR = 11'h080;
  localparam logic [10:0] V_MEML = 11'h050;
  localparam logic [10:0] V_MEMS = 11'h060;
  localparam logic [10:0] V_WB   = 11'h054;
  localparam logic [10:0] V_HALT = 11'h002;
  localparam logic [10:0] V_HFLT = 11'h003;

  logic       clk = 1'b0;
  logic       rst, rst_a, rst_b, sel;
  logic [2:0] opcode;
  logic       exec_waiting;

  always #5 clk = ~clk;

  fetch_sequencer_if bus_a ();
  fetch_sequencer_if bus_b ();

  assign rst_a = sel ? 1'b1 : rst;
  assign rst_b = sel ? rst : 1'b1;
  assign bus_a.opcode       = opcode;
  assign bus_a.exec_waiting = exec_waiting;
  assign bus_b.opcode       = opcode;
  assign bus_b.exec_waiting = exec_waiting;

  fetch_sequencer #(.MEM_LAT(1), .EXEC_GUARD(G), .EXEC_TIMEOUT(T)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a));
  fetch_sequencer #(.MEM_LAT(2), .EXEC_GUARD(G), .EXEC_TIMEOUT(T)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b));

  logic [10:0] vec_a, vec_b;
  assign vec_a = {bus_a.reset_pc, bus_a.load_pc, bus_a.load_ir, bus_a.load_addr, bus_a.addr_sel,
                  bus_a.mem_cmd, bus_a.exec_start, bus_a.ldr_wb, bus_a.halted, bus_a.fault};
  assign vec_b = {bus_b.reset_pc, bus_b.load_pc, bus_b.load_ir, bus_b.load_addr, bus_b.addr_sel,
                  bus_b.mem_cmd, bus_b.exec_start, bus_b.ldr_wb, bus_b.halted, bus_b.fault};

  // Expected trace and the stimulus that goes with each cycle.
  logic [10:0] eq[$];
  logic        wq[$];
  logic        rq[$];
  logic [2:0]  oq[$];
  int exec_idx, mem_idx;
  int n_chk = 0, n_fail = 0;
  int cur = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input int idx, input logic [10:0] act, input logic [10:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic push(input logic [10:0] v, input logic w, input logic [2:0] op);
    eq.push_back(v);
    wq.push_back(w);
    rq.push_back(1'b0);
    oq.push_back(op);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] rop();
    return 3'($urandom_range(0, 7));
  endfunction

  // One instruction from IF onward. kind: 0 = returns to IF, 1 = halt, 2 = timeout fault.
  task automatic build_instr(input int ml, input logic [2:0] op, input int ws, output int kind);
    int done, len;
    kind = 0;
    for (int c = 0; c < ml; c++) push(V_IF, rb(), rop());
    push(V_LDIR, rb(), rop());
    push(V_UPC, rb(), rop());
    if (op == 3'b111) begin
      push(V_IDLE, rb(), op);
      kind = 1;
      return;
    end
    push(V_DEC, rb(), op);
    exec_idx = eq.size();
    done = (ws > G) ? ws : G;
    len  = (done <= T - 2) ? done + 1 : T;
    for (int j = 0; j < len; j++) push(V_IDLE, (j < G) ? rb() : (j >= ws), op);
    if (done > T - 2) begin
      kind = 2;
      return;
    end
    if (op == 3'b011 || op == 3'b100) begin
      push(V_ADDR, rb(), op);
      mem_idx = eq.size();
      for (int c = 0; c < ml; c++) push((op == 3'b011) ? V_MEML : V_MEMS, rb(), op);
      if (op == 3'b011) push(V_WB, rb(), op);
    end
  endtask

  task automatic add_halt(input int n, input bit f);
    for (int i = 0; i < n; i++) push(f ? V_HFLT : V_HALT, rb(), rop());
  endtask

  task automatic do_reset();
    rq[rq.size() - 1] = 1'b1;
    push(V_RST, rb(), rop());
  endtask

  task automatic trim(input int n);
    while (eq.size() > n) begin
      void'(eq.pop_back());
      void'(wq.pop_back());
      void'(rq.pop_back());
      void'(oq.pop_back());
    end
  endtask

  task automatic clear_prog();
    eq.delete(); wq.delete(); rq.delete(); oq.delete();
    push(V_RST, 1'b0, 3'b000);
  endtask

  function automatic int count_bit(input int b);
    int s = 0;
    for (int i = 0; i < eq.size(); i++) s += int'(eq[i][b]);
    return s;
  endfunction

  // Shared tail: random instructions, mid-access resets, timeout, halt.
  task automatic build_tail(input int ml);
    int k, te;
    for (int n = 0; n < 14; n++) begin
      build_instr(ml, 3'($urandom_range(0, 6)), $urandom_range(0, 15), k);
      if (k != 0) begin
        add_halt(3, k == 2);
        do_reset();
      end
    end
    build_instr(ml, 3'b001, 99, k);
    trim(exec_idx + 4);
    do_reset();
    build_instr(ml, 3'b011, 4, k);
    trim(mem_idx + 1);
    do_reset();
    build_instr(ml, 3'b100, 4, k);
    trim(mem_idx + ml);
    do_reset();
    build_instr(ml, 3'b101, 99, k);
    te = exec_idx;
    add_halt(5, 1'b1);
    check("model_tmo_last_exec", te + 14, eq[te + 14], V_IDLE);
    check("model_tmo_fault", te + 15, eq[te + 15], V_HFLT);
    do_reset();
    build_instr(ml, 3'b111, 0, k);
    add_halt(20, 1'b0);
    do_reset();
    build_instr(ml, 3'b010, 3, k);
  endtask

  task automatic run_prog();
    for (int i = 0; i < eq.size(); i++) begin
      @(posedge clk);
      #1;
      rst          = rq[i];
      opcode       = oq[i];
      exec_waiting = wq[i];
      cur          = i;
      cmp_en       = 1'b1;
    end
    @(posedge clk);
    #1 cmp_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cmp_en) check(sel ? "trace_lat2" : "trace_lat1", cur, sel ? vec_b : vec_a, eq[cur]);
  end

  initial begin
    int k;
    rst = 1'b1; sel = 1'b0; opcode = 3'b000; exec_waiting = 1'b0;

    // MEM_LAT = 1
    clear_prog();
    build_instr(1, 3'b110, G + 3, k);
    check("model_rst", 0, eq[0], V_RST);
    check("model_if", 1, eq[1], V_IF);
    check("model_ldir", 2, eq[2], V_LDIR);
    check("model_upc", 3, eq[3], V_UPC);
    check("model_dec", 4, eq[4], V_DEC);
    check("model_start_once", 0, 11'(count_bit(3)), 11'd1);
    check("model_no_load_addr", 0, 11'(count_bit(7)), 11'd0);
    check("model_exec_len", eq.size(), 11'(eq.size()), 11'd11);
    build_instr(1, 3'b011, $urandom_range(0, 6), k);
    build_instr(1, 3'b100, $urandom_range(0, 6), k);
    build_tail(1);
    repeat (2) @(posedge clk);
    run_prog();

    // MEM_LAT = 2
    rst = 1'b1;
    sel = 1'b1;
    repeat (2) @(posedge clk);
    clear_prog();
    build_instr(2, 3'b011, 0, k);
    check("model_ldr_addr", 9, eq[9], V_ADDR);
    check("model_ldr_mem0", 10, eq[10], V_MEML);
    check("model_ldr_mem1", 11, eq[11], V_MEML);
    check("model_ldr_wb", 12, eq[12], V_WB);
    check("model_wb_once", 0, 11'(count_bit(2)), 11'd1);
    build_instr(2, 3'b100, 5, k);
    check("model_after_wb", 13, eq[13], V_IF);
    check("model_str_no_wb", 0, 11'(count_bit(2)), 11'd1);
    build_tail(2);
    run_prog();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
